seg_scan_driver: RTL
====================

Name: seg_scan_driver

Overview:
- Time-multiplexed driver for a common-anode multi-digit 7-segment display.
- Takes NUM_DIGITS 4-bit glyph codes with a load strobe and double-buffers them so updates land only at frame boundaries.
- Scans one digit per dwell period and applies leading-zero blanking, per-digit blink and global blank.
- Sits between the datapath/status logic and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=2)
SCAN_DIV, 50000, clk cycles per digit dwell (>=2)
BLINK_FRAMES, 64, complete scan frames per blink-phase toggle (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
load  in  1  one-cycle strobe; captures codes into shadow buffer
codes  in  4*NUM_DIGITS  glyph codes; digit i = codes[4i+3:4i], digit 0 rightmost/least significant
blink_mask  in  NUM_DIGITS  1 = digit blinks
lz_en  in  1  leading-zero suppression enable
blank_all  in  1  forces all anodes off
seg  out  7  active-low segments {g,f,e,d,c,b,a} = seg[6:0]
an  out  NUM_DIGITS  active-low digit enables, one-hot-low while displaying
upd_pend  out  1  shadow holds a load not yet committed
frame_tick  out  1  one-cycle pulse when scan index wraps to 0

Behaviour:
- Reset (async, immediate):
  - seg=7'b1111111; an=all ones; upd_pend=0; frame_tick=0.
  - Prescaler=0; scan index=0; blink_phase=0.
  - Shadow and active buffers hold all 4'hA (off).
- Glyph map (active low, 0=lit):
  - 0:1000000  1:1111001  2:0100100  3:0110000
  - 4:0011001  5:0010010  6:0000010  7:1011000
  - 8:0000000  9:0010000  A:off 1111111  B:'-' 0111111
  - C:'H' 0001001  D:'L' 1000111  E:'E' 0000110  F:'P' 0001100
- Prescaler:
  - Counts 0..SCAN_DIV-1, then wraps.
  - On the cycle it equals SCAN_DIV-1, the index advances by 1, wrapping NUM_DIGITS-1 -> 0.
- Frame boundary = the cycle the index wraps to 0. On that clock edge:
  - frame_tick registers 1 for exactly one cycle.
  - If upd_pend=1, active <= shadow and upd_pend clears.
  - The frame counter increments; after BLINK_FRAMES frames, blink_phase toggles and the counter clears.
- Load handling:
  - load=1 captures codes into shadow and sets upd_pend=1.
  - A load while pending overwrites shadow; only the last load commits.
  - Load on a frame-boundary cycle: the commit uses the shadow value from before this edge, the new codes enter shadow, and upd_pend stays/becomes 1 (committed at the next boundary).
- Outputs are registered, 1 cycle after the prescaler/index state that selects them.
  - Anode guard: in the first cycle of every dwell (prescaler==0 registered state), an=all ones to avoid ghosting.
  - Rest of the dwell: an[idx]=0, others 1.
- Digit content, priority high to low:
  1. blank_all=1 -> an all ones, seg=1111111.
  2. blink_mask[idx]=1 and blink_phase=1 -> seg=1111111, anode still driven.
  3. lz_en=1, idx>0, and active digits idx..NUM_DIGITS-1 all equal 4'h0 -> seg=1111111. Digit 0 is never suppressed.
  4. Otherwise seg = glyph(active[idx]).
- blank_all, blink_mask and lz_en are sampled live every cycle, not buffered.
- Deasserting rst mid-frame restarts the scan at index 0 with a guard cycle; all loads and pending updates are lost.
- Width rules:
  - Index width = clog2(NUM_DIGITS).
  - Prescaler width = clog2(SCAN_DIV).
  - Frame counter width = clog2(BLINK_FRAMES+1).
  - No counter may exceed its terminal value; NUM_DIGITS need not be a power of two.

Decomposition:
- Shared package seg_pkg holds:
  - Glyph code constants: GLYPH_OFF=4'hA, GLYPH_DASH=4'hB, GLYPH_H=4'hC, GLYPH_L=4'hD, GLYPH_E=4'hE, GLYPH_P=4'hF.
  - SEG_BLANK=7'b1111111.
  - A function returning the 7-bit pattern for a code.
- One combinational sub-module, glyph_decode (4-bit code -> 7-bit active-low pattern), instantiated once on the muxed digit.
- The scan/buffer/blink logic stays in seg_scan_driver.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2):
1. Reset mid-scan: assert rst asynchronously -> seg=1111111, an=1111 immediately. After release, the first 17 cycles show guard then an=1110 with seg=1111111 (off buffer), and frame_tick pulses every 16 cycles.
2. Load codes=16'h1234 mid-frame -> upd_pend=1 until the next frame_tick edge, then clears. In the following frame, an=1110 gives seg=0011001 ('4'), and an=0111 gives seg=1111001 ('1').
3. Double load 16'h1111 then 16'h5678 within one frame, plus a load on the exact boundary cycle -> only the pre-boundary shadow (5678) commits. The boundary-cycle load remains pending, with upd_pend=1.
4. codes=16'h0070, lz_en=1 -> digits 3 and 2 blank, digit 1 shows 1011000, digit 0 shows 1000000. With lz_en=0, digits 3 and 2 show 1000000.
5. blink_mask=4'b0001, codes=16'hCEDF -> digit 0 shows 'P' for 2 frames, then 1111111 for 2 frames (anode still low), alternating. Digits 1-3 are unaffected.
6. blank_all pulsed for 5 cycles -> an=1111 and seg=1111111 in each affected registered cycle. The scan index keeps advancing, so the display resumes at the correct digit.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared glyph codes and segment patterns for the 7-segment scan driver
package seg_pkg;

  localparam logic [3:0] GLYPH_OFF  = 4'hA;
  localparam logic [3:0] GLYPH_DASH = 4'hB;
  localparam logic [3:0] GLYPH_H    = 4'hC;
  localparam logic [3:0] GLYPH_L    = 4'hD;
  localparam logic [3:0] GLYPH_E    = 4'hE;
  localparam logic [3:0] GLYPH_P    = 4'hF;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] glyph_pattern(input logic [3:0] code);
    logic [6:0] p;
    case (code)
      4'h0:       p = 7'b1000000;
      4'h1:       p = 7'b1111001;
      4'h2:       p = 7'b0100100;
      4'h3:       p = 7'b0110000;
      4'h4:       p = 7'b0011001;
      4'h5:       p = 7'b0010010;
      4'h6:       p = 7'b0000010;
      4'h7:       p = 7'b1011000;
      4'h8:       p = 7'b0000000;
      4'h9:       p = 7'b0010000;
      GLYPH_OFF:  p = SEG_BLANK;
      GLYPH_DASH: p = 7'b0111111;
      GLYPH_H:    p = 7'b0001001;
      GLYPH_L:    p = 7'b1000111;
      GLYPH_E:    p = 7'b0000110;
      default:    p = 7'b0001100;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/glyph_decode.sv
// rtl/glyph_decode.sv - combinational 4-bit glyph code to active-low segment pattern
module glyph_decode
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pattern
);

  assign pattern = glyph_pattern(code);

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - double-buffered multiplexed common-anode 7-segment scan driver
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] codes,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_en,
  input  logic                    blank_all,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    upd_pend,
  output logic                    frame_tick
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam int CW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] CODES_OFF = {NUM_DIGITS{GLYPH_OFF}};

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FW-1:0]         frame_cnt_q, frame_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [CW-1:0]         shadow_q, shadow_d;
  logic [CW-1:0]         active_q, active_d;
  logic                  upd_pend_q, upd_pend_d;
  logic                  frame_tick_q, frame_tick_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic       dwell_end;
  logic       frame_end;
  logic [3:0] cur_code;
  logic       cur_blink;
  logic       lead_zero;
  logic [6:0] cur_pattern;

  glyph_decode u_glyph_decode (
    .code    (cur_code),
    .pattern (cur_pattern)
  );

  always_comb begin
    presc_d       = presc_q;
    idx_d         = idx_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    upd_pend_d    = upd_pend_q;
    frame_tick_d  = 1'b0;
    seg_d         = SEG_BLANK;
    an_d          = '1;
    cur_code      = GLYPH_OFF;
    cur_blink     = 1'b0;
    lead_zero     = 1'b1;

    dwell_end = (presc_q == PW'(SCAN_DIV - 1));
    frame_end = dwell_end && (idx_q == IW'(NUM_DIGITS - 1));

    presc_d = dwell_end ? '0 : presc_q + PW'(1);
    if (dwell_end) begin
      idx_d = frame_end ? '0 : idx_q + IW'(1);
    end

    // Commit reads the pre-edge shadow, so a boundary-cycle load stays pending.
    if (frame_end) begin
      frame_tick_d = 1'b1;
      if (upd_pend_q) begin
        active_d   = shadow_q;
        upd_pend_d = 1'b0;
      end
      if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end

    if (load) begin
      shadow_d   = codes;
      upd_pend_d = 1'b1;
    end

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_code  = active_q[4*i +: 4];
        cur_blink = blink_mask[i];
      end
      if (i >= int'(idx_q) && active_q[4*i +: 4] != 4'h0) begin
        lead_zero = 1'b0;
      end
    end

    if (blank_all) begin
      seg_d = SEG_BLANK;
    end else if (cur_blink && blink_phase_q) begin
      seg_d = SEG_BLANK;
    end else if (lz_en && idx_q != '0 && lead_zero) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = cur_pattern;
    end

    // First cycle of each dwell keeps all anodes off to avoid ghosting.
    if (!blank_all && presc_q != '0) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_d[i] = (idx_q != IW'(i));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q       <= '0;
      idx_q         <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      shadow_q      <= CODES_OFF;
      active_q      <= CODES_OFF;
      upd_pend_q    <= 1'b0;
      frame_tick_q  <= 1'b0;
      seg_q         <= SEG_BLANK;
      an_q          <= '1;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      upd_pend_q    <= upd_pend_d;
      frame_tick_q  <= frame_tick_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign upd_pend   = upd_pend_q;
  assign frame_tick = frame_tick_q;

endmodule
